bus_fabric: RTL and testbench
=============================

Name: bus_fabric

Overview:
- Parametrised successor to the SoC's hard-coded combinational read mux.
- Sits between the CPU master port and N peripheral slaves. Decodes addresses from per-slave base/mask parameters and runs each access through a req/ready handshake, so slaves may insert wait states.
- Enforces a per-access timeout and answers unmapped addresses with a bus error.
- Captures the first fault in a small register window and raises an interrupt line for the interrupt controller.

Parameters:
- N_SLAVES, 4, number of slave ports (1..8).
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- SLAVE_BASE, {16'h0430,16'h0420,16'h0400,16'h0000}, packed N_SLAVES*ADDR_W base addresses; slave i is in bits [i*ADDR_W +: ADDR_W].
- SLAVE_MASK, {16'hFFF0,16'hFFF0,16'hFFFE,16'hFC00}, packed compare masks.
- TIMEOUT, 15, maximum ACCESS cycles before abort; 0 disables the timeout.
- ERR_BASE, 16'h04F0, base of the 2-word fabric status window (bit 0 ignored).

Ports:
- i_clk  in  1  clock; single clock domain.
- i_reset  in  1  synchronous, active-high reset.
- i_m_req  in  1  master access request; sampled only in IDLE.
- i_m_we  in  1  master write enable.
- i_m_addr  in  ADDR_W  master address.
- i_m_wdata  in  DATA_W  master write data.
- o_m_rdata  out  DATA_W  read data; valid while o_m_ready=1.
- o_m_ready  out  1  one-cycle completion pulse.
- o_m_err  out  1  access failed; qualified by o_m_ready.
- o_s_sel  out  N_SLAVES  one-hot slave select.
- o_s_we  out  1  slave write enable.
- o_s_addr  out  ADDR_W  latched address.
- o_s_wdata  out  DATA_W  latched write data.
- i_s_rdata  in  N_SLAVES*DATA_W  packed slave read data.
- i_s_ready  in  N_SLAVES  per-slave ready.
- o_err_int  out  1  level interrupt; equals STATUS.valid.

Behaviour:
- Reset values:
  - FSM in IDLE.
  - o_m_ready=0, o_m_err=0, o_m_rdata=0.
  - o_s_sel=0, o_s_we=0, o_s_addr=0, o_s_wdata=0.
  - STATUS=0, FAULT_ADDR=0, timeout counter=0.
  - Reset mid-access aborts the access: no ready pulse is produced.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - On i_m_req=1: latch addr, we and wdata, decode, and go to ACCESS.
  - i_m_req while not in IDLE is ignored.
- Decode priority:
  - The fabric window (addr[ADDR_W-1:1]==ERR_BASE[ADDR_W-1:1]) takes priority.
  - Otherwise the lowest index i with (addr & MASK_i)==BASE_i is selected.
  - If nothing matches, the access is unmapped.
- ACCESS, slave target:
  - o_s_sel[i]=1; o_s_we equals the latched we.
  - The counter clears on entry and increments in each ACCESS cycle that has i_s_ready[i]=0.
  - If i_s_ready[i]=1: capture i_s_rdata slice i (writes yield 0), then go to RESP with err=0.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: abort, set rdata=0, go to RESP with err=1, and log a timeout.
  - Ready takes precedence over timeout in the same cycle.
- ACCESS, unmapped target:
  - o_s_sel=0.
  - Goes to RESP next cycle with err=1 and rdata=0, and logs an unmapped fault.
- ACCESS, fabric window:
  - o_s_sel=0; completes in 1 cycle.
  - Offset 0 reads STATUS = {.., ovf[3], we[2], timeout[1], valid[0]}.
  - Offset 1 reads FAULT_ADDR.
  - Any write to offset 0 clears STATUS and FAULT_ADDR.
  - Writes to offset 1 are ignored.
- RESP:
  - o_m_ready=1 for exactly one cycle, with o_m_rdata and o_m_err valid.
  - Then return to IDLE.
  - o_m_rdata holds its value until the next RESP.
- Latency: request accepted in cycle 0; a slave that is ready in its first ACCESS cycle (cycle 1) gives o_m_ready in cycle 2. In general, latency is 2 + wait states.
- Fault logging:
  - If valid=0: set valid, timeout and we, and load FAULT_ADDR.
  - If valid=1: set ovf only; the first fault is preserved.
- o_s_addr and o_s_wdata remain stable from ACCESS entry until the next accepted request.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=0, ACCESS=1, RESP=2).
  - STATUS bit indices (VALID=0, TO=1, WE=2, OVF=3).
  - Fabric register offsets.
- One natural sub-module: bus_decoder, a combinational parametrised base/mask matcher. Outputs one-hot select plus hit, and handles the fabric-window check.
- Timeout counter and error registers stay in bus_fabric.

Test Plan:
- Read 0x0010, slave0 ready immediately with rdata 0xBEEF -> o_m_ready in cycle 2, rdata=0xBEEF, err=0, o_s_sel=4'b0001 in cycle 1 only.
- Write 0x0421 data 0x1234, slave2 ready after 3 waits -> o_s_we=1 with wdata 0x1234 for 4 cycles; ready in cycle 5, err=0.
- Read 0x0422, slave2 never ready, TIMEOUT=15 -> after 15 ACCESS cycles: ready with err=1, rdata=0; STATUS=0x0003, FAULT_ADDR=0x0422, o_err_int=1.
- Read 0x8000 (unmapped) after a prior fault -> ready in cycle 2 with err=1; STATUS=0x000B; FAULT_ADDR unchanged.
- Write 0 to 0x04F0, then read 0x04F0 -> STATUS=0 and o_err_int=0 on both accesses.
- Assert i_reset during a wait state -> no o_m_ready pulse, o_s_sel=0 next cycle, and the next request completes normally.

Source files
------------

// File: rtl/bus_fabric_pkg.sv
// Shared encodings for the bus fabric: FSM states, target kinds, STATUS bits, register offsets.
package bus_fabric_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    TGT_SLAVE    = 2'd0,
    TGT_UNMAPPED = 2'd1,
    TGT_FABRIC   = 2'd2
  } target_e;

  localparam int unsigned STATUS_W   = 4;
  localparam int unsigned STAT_VALID = 0;
  localparam int unsigned STAT_TO    = 1;
  localparam int unsigned STAT_WE    = 2;
  localparam int unsigned STAT_OVF   = 3;

  // Word offsets inside the fabric status window (address bit 0)
  localparam logic REG_STATUS     = 1'b0;
  localparam logic REG_FAULT_ADDR = 1'b1;

endpackage

// File: rtl/bus_fabric_if.sv
// CPU-side and peripheral-side signals of the bus fabric.
interface bus_fabric_if #(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16
);
  logic                         i_m_req;
  logic                         i_m_we;
  logic [ADDR_W-1:0]            i_m_addr;
  logic [DATA_W-1:0]            i_m_wdata;
  logic [DATA_W-1:0]            o_m_rdata;
  logic                         o_m_ready;
  logic                         o_m_err;
  logic [N_SLAVES-1:0]          o_s_sel;
  logic                         o_s_we;
  logic [ADDR_W-1:0]            o_s_addr;
  logic [DATA_W-1:0]            o_s_wdata;
  logic [N_SLAVES*DATA_W-1:0]   i_s_rdata;
  logic [N_SLAVES-1:0]          i_s_ready;
  logic                         o_err_int;

  modport fabric (
    input  i_m_req, i_m_we, i_m_addr, i_m_wdata, i_s_rdata, i_s_ready,
    output o_m_rdata, o_m_ready, o_m_err, o_s_sel, o_s_we, o_s_addr, o_s_wdata, o_err_int
  );

  modport master (
    output i_m_req, i_m_we, i_m_addr, i_m_wdata,
    input  o_m_rdata, o_m_ready, o_m_err, o_err_int
  );

  modport slave (
    input  o_s_sel, o_s_we, o_s_addr, o_s_wdata,
    output i_s_rdata, i_s_ready
  );
endinterface

// File: rtl/bus_decoder.sv
// Combinational address decoder: fabric window first, then lowest matching base/mask slave.
module bus_decoder
  import bus_fabric_pkg::*;
#(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned ADDR_W   = 16,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = '0,
  parameter logic [ADDR_W-1:0] ERR_BASE = '0
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [N_SLAVES-1:0] sel_c,
  output logic                hit_c,
  output logic                fab_hit_c
);

  // Priority match; the fabric window masks every slave
  always_comb begin
    sel_c     = '0;
    hit_c     = 1'b0;
    fab_hit_c = (addr[ADDR_W-1:1] == ERR_BASE[ADDR_W-1:1]);
    if (!fab_hit_c) begin
      for (int i = 0; i < int'(N_SLAVES); i++) begin
        if (!hit_c &&
            ((addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W])) begin
          sel_c[i] = 1'b1;
          hit_c    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bus_fabric.sv
// Bus fabric: decodes CPU accesses onto N slaves with wait states, timeout and fault logging.
module bus_fabric
  import bus_fabric_pkg::*;
#(
  parameter int unsigned N_SLAVES = 4,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_BASE = {16'h0430, 16'h0420, 16'h0400, 16'h0000},
  parameter logic [N_SLAVES*ADDR_W-1:0] SLAVE_MASK = {16'hFFF0, 16'hFFF0, 16'hFFFE, 16'hFC00},
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [ADDR_W-1:0] ERR_BASE = 16'h04F0
) (
  input logic          i_clk,
  input logic          i_reset,
  bus_fabric_if.fabric bus
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_e               state_q, state_d;
  target_e              tgt_q, tgt_d;
  logic [N_SLAVES-1:0]  sel_q, sel_d, dec_sel_c;
  logic                 dec_hit_c, dec_fab_c;
  logic                 we_q, we_d, s_we_q, s_we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d, fault_addr_q, fault_addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d, rdata_q, rdata_d, slv_rdata_c;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ready_q, ready_d, err_q, err_d;
  logic                 slv_ready_c, timeout_c, log_fault_c;
  logic [STATUS_W-1:0]  status_q, status_d;

  bus_decoder #(
    .N_SLAVES  (N_SLAVES),
    .ADDR_W    (ADDR_W),
    .SLAVE_BASE(SLAVE_BASE),
    .SLAVE_MASK(SLAVE_MASK),
    .ERR_BASE  (ERR_BASE)
  ) u_decoder (
    .addr     (bus.i_m_addr),
    .sel_c    (dec_sel_c),
    .hit_c    (dec_hit_c),
    .fab_hit_c(dec_fab_c)
  );

  // Read data and ready of the currently selected slave
  always_comb begin
    slv_rdata_c = '0;
    for (int i = 0; i < int'(N_SLAVES); i++) begin
      if (sel_q[i]) slv_rdata_c = bus.i_s_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign slv_ready_c = |(bus.i_s_ready & sel_q);
  assign timeout_c   = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    tgt_d        = tgt_q;
    sel_d        = sel_q;
    we_d         = we_q;
    s_we_d       = s_we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    ready_d      = 1'b0;
    err_d        = err_q;
    status_d     = status_q;
    fault_addr_d = fault_addr_q;
    log_fault_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.i_m_req) begin
          state_d = ST_ACCESS;
          addr_d  = bus.i_m_addr;
          wdata_d = bus.i_m_wdata;
          we_d    = bus.i_m_we;
          cnt_d   = '0;
          sel_d   = dec_sel_c;
          s_we_d  = bus.i_m_we & dec_hit_c;
          tgt_d   = dec_fab_c ? TGT_FABRIC : (dec_hit_c ? TGT_SLAVE : TGT_UNMAPPED);
        end
      end

      ST_ACCESS: begin
        case (tgt_q)
          TGT_SLAVE: begin
            if (!slv_ready_c) cnt_d = cnt_q + CNT_W'(1);
            if (slv_ready_c) begin
              state_d = ST_RESP;
              rdata_d = we_q ? '0 : slv_rdata_c;
              err_d   = 1'b0;
            end else if (timeout_c) begin
              state_d     = ST_RESP;
              rdata_d     = '0;
              err_d       = 1'b1;
              log_fault_c = 1'b1;
            end
          end
          TGT_UNMAPPED: begin
            state_d     = ST_RESP;
            rdata_d     = '0;
            err_d       = 1'b1;
            log_fault_c = 1'b1;
          end
          TGT_FABRIC: begin
            state_d = ST_RESP;
            err_d   = 1'b0;
            if (we_q) begin
              rdata_d = '0;
              if (addr_q[0] == REG_STATUS) begin
                status_d     = '0;
                fault_addr_d = '0;
              end
            end else begin
              rdata_d = (addr_q[0] == REG_FAULT_ADDR) ? DATA_W'(fault_addr_q) : DATA_W'(status_q);
            end
          end
          default: state_d = ST_IDLE;
        endcase
        if (state_d == ST_RESP) begin
          ready_d = 1'b1;
          sel_d   = '0;
          s_we_d  = 1'b0;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // First fault is kept; later ones only flag overflow
    if (log_fault_c) begin
      if (!status_q[STAT_VALID]) begin
        status_d[STAT_VALID] = 1'b1;
        status_d[STAT_TO]    = (tgt_q == TGT_SLAVE);
        status_d[STAT_WE]    = we_q;
        fault_addr_d         = addr_q;
      end else begin
        status_d[STAT_OVF] = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      tgt_q        <= TGT_SLAVE;
      sel_q        <= '0;
      we_q         <= 1'b0;
      s_we_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
      status_q     <= '0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      tgt_q        <= tgt_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      s_we_q       <= s_we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      ready_q      <= ready_d;
      err_q        <= err_d;
      status_q     <= status_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  assign bus.o_m_rdata = rdata_q;
  assign bus.o_m_ready = ready_q;
  assign bus.o_m_err   = err_q;
  assign bus.o_s_sel   = sel_q;
  assign bus.o_s_we    = s_we_q;
  assign bus.o_s_addr  = addr_q;
  assign bus.o_s_wdata = wdata_q;
  assign bus.o_err_int = status_q[STAT_VALID];

endmodule

// File: tb/tb_bus_fabric.sv
// Randomized self-checking bench for bus_fabric against a transaction-level reference model.
module tb_bus_fabric;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int TO = 15;
  localparam int T_UNMAPPED = -1;
  localparam int T_FABRIC   = -2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_fabric_if #(.N_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  bus_fabric #(
    .N_SLAVES  (NS),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .SLAVE_BASE({16'h0430, 16'h0420, 16'h0400, 16'h0000}),
    .SLAVE_MASK({16'hFFF0, 16'hFFF0, 16'hFFFE, 16'hFC00}),
    .TIMEOUT   (TO),
    .ERR_BASE  (16'h04F0)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int vectors = 0;
  int errors  = 0;

  logic [15:0] base_tab [4] = '{16'h0000, 16'h0400, 16'h0420, 16'h0430};
  logic [15:0] mask_tab [4] = '{16'hFC00, 16'hFFFE, 16'hFFF0, 16'hFFF0};

  // Reference fault-log state
  logic        m_valid, m_to, m_we, m_ovf;
  logic [15:0] m_fault;

  function automatic int ref_target(input logic [15:0] a);
    if ((a >> 1) == (16'h04F0 >> 1)) return T_FABRIC;
    for (int i = 0; i < 4; i++) if ((a & mask_tab[i]) == base_tab[i]) return i;
    return T_UNMAPPED;
  endfunction

  function automatic void model_clear();
    m_valid = 1'b0; m_to = 1'b0; m_we = 1'b0; m_ovf = 1'b0; m_fault = 16'h0;
  endfunction

  // One full transaction; waits < 0 means the slave never answers
  task automatic do_access(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           input int waits, input logic [15:0] rd_val);
    int          tgt, exp_lat;
    logic        exp_err, exp_swe;
    logic [15:0] exp_rd;
    logic [3:0]  exp_sel;
    logic [15:0] srd [4];
    tgt = ref_target(addr);
    for (int i = 0; i < 4; i++) srd[i] = 16'($urandom);
    exp_sel = 4'b0;
    if (tgt >= 0) begin
      srd[tgt] = rd_val;
      exp_sel[tgt] = 1'b1;
    end
    exp_swe = we && (tgt >= 0);
    if (tgt >= 0) begin
      if (waits >= 0 && waits < TO) begin
        exp_lat = waits + 2; exp_err = 1'b0; exp_rd = we ? 16'h0 : rd_val;
      end else begin
        exp_lat = TO + 1; exp_err = 1'b1; exp_rd = 16'h0;
      end
    end else if (tgt == T_UNMAPPED) begin
      exp_lat = 2; exp_err = 1'b1; exp_rd = 16'h0;
    end else begin
      exp_lat = 2; exp_err = 1'b0;
      if (we) exp_rd = 16'h0;
      else if (addr[0]) exp_rd = m_fault;
      else exp_rd = {12'h0, m_ovf, m_we, m_to, m_valid};
    end
    if (exp_err) begin
      if (!m_valid) begin
        m_valid = 1'b1; m_to = (tgt >= 0); m_we = we; m_fault = addr;
      end else begin
        m_ovf = 1'b1;
      end
    end else if (tgt == T_FABRIC && we && !addr[0]) begin
      model_clear();
    end

    bus.i_s_rdata = {srd[3], srd[2], srd[1], srd[0]};
    bus.i_s_ready = 4'b0;
    bus.i_m_req   = 1'b1;
    bus.i_m_we    = we;
    bus.i_m_addr  = addr;
    bus.i_m_wdata = wdata;
    for (int c = 1; c <= exp_lat; c++) begin
      @(negedge clk);
      bus.i_m_req   = 1'($urandom);
      bus.i_m_we    = 1'($urandom);
      bus.i_m_addr  = 16'($urandom);
      bus.i_m_wdata = 16'($urandom);
      bus.i_s_ready = (tgt >= 0 && c == waits + 1) ? exp_sel : 4'b0;
      if (c < exp_lat) begin
        vectors++;
        if (bus.o_m_ready !== 1'b0) begin
          errors++; $display("FAIL early_ready @%h c%0d: got %b expected 0", addr, c, bus.o_m_ready);
        end
        vectors++;
        if (bus.o_s_sel !== exp_sel) begin
          errors++; $display("FAIL access_sel @%h c%0d: got %b expected %b", addr, c, bus.o_s_sel, exp_sel);
        end
        vectors++;
        if (bus.o_s_we !== exp_swe) begin
          errors++; $display("FAIL access_we @%h c%0d: got %b expected %b", addr, c, bus.o_s_we, exp_swe);
        end
        vectors++;
        if (bus.o_s_addr !== addr || bus.o_s_wdata !== wdata) begin
          errors++; $display("FAIL access_addr_wdata c%0d: got %h/%h expected %h/%h",
                             c, bus.o_s_addr, bus.o_s_wdata, addr, wdata);
        end
      end else begin
        vectors++;
        if (bus.o_m_ready !== 1'b1) begin
          errors++; $display("FAIL resp_ready @%h lat%0d: got %b expected 1", addr, c, bus.o_m_ready);
        end
        vectors++;
        if (bus.o_m_rdata !== exp_rd) begin
          errors++; $display("FAIL resp_rdata @%h: got %h expected %h", addr, bus.o_m_rdata, exp_rd);
        end
        vectors++;
        if (bus.o_m_err !== exp_err) begin
          errors++; $display("FAIL resp_err @%h: got %b expected %b", addr, bus.o_m_err, exp_err);
        end
        vectors++;
        if (bus.o_s_sel !== 4'b0) begin
          errors++; $display("FAIL resp_sel @%h: got %b expected 0000", addr, bus.o_s_sel);
        end
        vectors++;
        if (bus.o_err_int !== m_valid) begin
          errors++; $display("FAIL err_int @%h: got %b expected %b", addr, bus.o_err_int, m_valid);
        end
      end
    end
    @(negedge clk);
    bus.i_m_req   = 1'b0;
    bus.i_s_ready = 4'b0;
    vectors++;
    if (bus.o_m_ready !== 1'b0 || bus.o_s_sel !== 4'b0) begin
      errors++; $display("FAIL idle_after @%h: got ready %b sel %b expected 0 0000",
                         addr, bus.o_m_ready, bus.o_s_sel);
    end
    vectors++;
    if (bus.o_m_rdata !== exp_rd || bus.o_s_addr !== addr || bus.o_s_wdata !== wdata) begin
      errors++; $display("FAIL hold @%h: got %h/%h/%h expected %h/%h/%h", addr,
                         bus.o_m_rdata, bus.o_s_addr, bus.o_s_wdata, exp_rd, addr, wdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_m_req = 1'b0; bus.i_m_we = 1'b0; bus.i_m_addr = 16'h0; bus.i_m_wdata = 16'h0;
    bus.i_s_rdata = '0; bus.i_s_ready = 4'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.o_m_ready, bus.o_m_err, bus.o_err_int, bus.o_s_we} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000",
                         {bus.o_m_ready, bus.o_m_err, bus.o_err_int, bus.o_s_we});
    end
    vectors++;
    if (bus.o_m_rdata !== 16'h0 || bus.o_s_sel !== 4'b0) begin
      errors++; $display("FAIL reset_rdata_sel: got %h %b expected 0000 0000", bus.o_m_rdata, bus.o_s_sel);
    end
    vectors++;
    if (bus.o_s_addr !== 16'h0 || bus.o_s_wdata !== 16'h0) begin
      errors++; $display("FAIL reset_addr: got %h %h expected 0000 0000", bus.o_s_addr, bus.o_s_wdata);
    end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    do_access(1'b0, 16'h0010, 16'h0000, 0, 16'hBEEF);
  endtask

  task automatic test_write_waits();
    do_access(1'b1, 16'h0421, 16'h1234, 3, 16'h5A5A);
  endtask

  task automatic test_timeout();
    do_access(1'b0, 16'h0422, 16'h0000, -1, 16'h7777);
    do_access(1'b0, 16'h04F0, 16'h0000, 0, 16'h0);
    do_access(1'b0, 16'h04F1, 16'h0000, 0, 16'h0);
  endtask

  task automatic test_unmapped();
    do_access(1'b0, 16'h8000, 16'h0000, 0, 16'h0);
    do_access(1'b0, 16'h04F0, 16'h0000, 0, 16'h0);
    do_access(1'b0, 16'h04F1, 16'h0000, 0, 16'h0);
  endtask

  task automatic test_clear();
    do_access(1'b1, 16'h04F0, 16'h0000, 0, 16'h0);
    do_access(1'b0, 16'h04F0, 16'h0000, 0, 16'h0);
  endtask

  task automatic test_decode_edges();
    do_access(1'b0, 16'h03FF, 16'h0000, 1, 16'h1111);
    do_access(1'b0, 16'h0401, 16'h0000, 0, 16'h2222);
    do_access(1'b1, 16'h0402, 16'hABCD, 0, 16'h0);
    do_access(1'b0, 16'h043F, 16'h0000, 2, 16'h3333);
    do_access(1'b0, 16'h0430, 16'h0000, TO - 1, 16'h4444);
    do_access(1'b0, 16'h0430, 16'h0000, TO, 16'h4545);
    do_access(1'b1, 16'h04F1, 16'hFFFF, 0, 16'h0);
    do_access(1'b0, 16'h04F1, 16'h0000, 0, 16'h0);
    do_access(1'b0, 16'h0440, 16'h0000, 0, 16'h0);
    do_access(1'b0, 16'h04F0, 16'h0000, 0, 16'h0);
  endtask

  task automatic test_reset_mid();
    bus.i_s_rdata = {4{16'h9999}};
    bus.i_s_ready = 4'b0;
    bus.i_m_req = 1'b1; bus.i_m_we = 1'b0; bus.i_m_addr = 16'h0400; bus.i_m_wdata = 16'h0;
    @(negedge clk);
    bus.i_m_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.o_m_ready !== 1'b0 || bus.o_s_sel !== 4'b0010) begin
      errors++; $display("FAIL rst_mid_wait: got %b %b expected 0 0010", bus.o_m_ready, bus.o_s_sel);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.o_m_ready !== 1'b0 || bus.o_s_sel !== 4'b0 || bus.o_s_addr !== 16'h0 || bus.o_err_int !== 1'b0) begin
      errors++; $display("FAIL rst_mid_abort: got %b %b %h %b expected 0 0000 0000 0",
                         bus.o_m_ready, bus.o_s_sel, bus.o_s_addr, bus.o_err_int);
    end
    rst = 1'b0;
    model_clear();
    @(negedge clk);
    vectors++;
    if (bus.o_m_ready !== 1'b0 || bus.o_s_sel !== 4'b0) begin
      errors++; $display("FAIL rst_mid_after: got %b %b expected 0 0000", bus.o_m_ready, bus.o_s_sel);
    end
    do_access(1'b0, 16'h0401, 16'h0000, 1, 16'hC0DE);
    do_access(1'b0, 16'h04F0, 16'h0000, 0, 16'h0);
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: a = {6'b0, 10'($urandom)};
        1: a = 16'h0400 | 16'($urandom_range(0, 1));
        2: a = 16'h0420 | 16'($urandom_range(0, 15));
        3: a = 16'h0430 | 16'($urandom_range(0, 15));
        4: a = 16'h04F0 | 16'($urandom_range(0, 1));
        default: a = 16'($urandom);
      endcase
      do_access(1'($urandom), a, 16'($urandom), int'($urandom_range(0, 17)), 16'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_waits();
    test_timeout();
    test_unmapped();
    test_clear();
    test_decode_edges();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
